// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// States, lane constants and the byte-lane merge helper.
package dmem_arb_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RMW_WR = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int          LANES   = 4;
    localparam logic [3:0]  BE_FULL = 4'hF;

    // Per lane: enabled lanes take store data, others keep memory data
    function automatic logic [31:0] be_merge(
        input logic [31:0] wd,
        input logic [31:0] rd,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = rd;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bundles for the data-memory arbiter.
// master = side that drives the request / memory command.
interface dmem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata, err
    );
    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata, err
    );
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;

    modport master (output we, a, wd, input rd);
    modport slave  (input we, a, wd, output rd);
endinterface

// File: rtl/dmem_rr_arb2.sv
// Two-input round-robin arbiter with a registered priority pointer.
// Pointer moves to the loser of each issued grant.
module dmem_rr_arb2 #(
    parameter int RESET_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       ptr
);

    // Lone request wins outright; a tie goes to the pointer
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
            else              gnt = req;
        end
    end

    // Favour the other requester after every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ptr <= (RESET_PRIO != 0);
        else if (advance) ptr <= gnt[0];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between two requesters.
// Optional: DMEM_ARB_ALIGN_CHK_EN enables misaligned-access errors.
module dmem_arbiter
    import dmem_arb_defs::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RESET_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    dmem_req_if.slave   m0,
    dmem_req_if.slave   m1,
    dmem_mem_if.master  mem
);

    state_t            state_q, state_d;
    logic [1:0]        gnt;
    logic              ptr;
    logic              grant_en;
    logic              sel;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [3:0]        req_be;
    logic              req_err;

    logic              lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        lat_be;
    logic              lat_err;
    logic [DATA_W-1:0] dreg;

    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata_o;

    assign grant_en = !rst && (state_q == IDLE || state_q == RESP);

    dmem_rr_arb2 #(.RESET_PRIO(RESET_PRIO)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({m1.req, m0.req}),
        .enable  (grant_en),
        .advance (|gnt),
        .gnt     (gnt),
        .ptr     (ptr)
    );

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign sel       = gnt[1];
    assign req_we    = sel ? m1.we    : m0.we;
    assign req_addr  = sel ? m1.addr  : m0.addr;
    assign req_wdata = sel ? m1.wdata : m0.wdata;
    assign req_be    = sel ? m1.be    : m0.be;

`ifdef DMEM_ARB_ALIGN_CHK_EN
    assign req_err = (req_addr[1:0] != 2'b00) &&
                     (!req_we || req_be != BE_FULL);
`else
    assign req_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latch the winning request when its grant issues
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_id    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_err   <= 1'b0;
        end else if (|gnt) begin
            lat_id    <= sel;
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            lat_err   <= req_err;
        end
    end

    // Capture load data or the merged word for a partial store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dreg <= '0;
        end else if (state_q == ACCESS) begin
            if (lat_err)     dreg <= '0;
            else if (!lat_we) dreg <= mem.rd;
            else             dreg <= be_merge(lat_wdata, mem.rd, lat_be);
        end
    end

    // Next state and registered-state-decoded outputs
    always_comb begin
        state_d = state_q;
        mem.we  = 1'b0;
        mem.a   = '0;
        mem.wd  = '0;
        rvalid0 = 1'b0;
        rvalid1 = 1'b0;
        rdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (|gnt) state_d = ACCESS;
            end
            ACCESS: begin
                mem.a = lat_addr;
                if (lat_err || !lat_we ||
                    lat_be == BE_FULL || lat_be == 4'h0) begin
                    state_d = RESP;
                end else begin
                    state_d = RMW_WR;
                end
                if (!lat_err && lat_we && lat_be == BE_FULL) begin
                    mem.we = 1'b1;
                    mem.wd = lat_wdata;
                end
            end
            RMW_WR: begin
                mem.a   = lat_addr;
                mem.we  = 1'b1;
                mem.wd  = dreg;
                state_d = RESP;
            end
            RESP: begin
                rvalid0 = !lat_id;
                rvalid1 = lat_id;
                rdata_o = lat_we ? '0 : dreg;
                state_d = (|gnt) ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m0.rvalid = rvalid0;
    assign m1.rvalid = rvalid1;
    assign m0.rdata  = rvalid0 ? rdata_o : '0;
    assign m1.rdata  = rvalid1 ? rdata_o : '0;
    assign m0.err    = rvalid0 & lat_err;
    assign m1.err    = rvalid1 & lat_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed cases then random traffic.
// Expected responses come from a word-array model updated in grant order.
module tb_dmem_arbiter;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   sb_en = 1;

    exp_t sb[$];
    wr_t  wlog[$];
    int   glog[$];

    logic [31:0] mem    [0:1023];
    logic [31:0] refmem [0:15];
    logic        pre_en;
    logic [9:0]  pre_idx;
    logic [31:0] pre_val;

    dmem_req_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    dmem_req_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    dmem_mem_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RESET_PRIO(0)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_if),
        .m1  (m1_if),
        .mem (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: synchronous write, combinational read, word index a[11:2]
    always @(posedge clk) begin
        if (pre_en)         mem[pre_idx] <= pre_val;
        else if (mem_if.we) mem[mem_if.a[11:2]] <= mem_if.wd;
    end
    assign mem_if.rd = mem[mem_if.a[11:2]];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    function automatic logic gnt_of(input int id);
        return (id == 0) ? m0_if.gnt : m1_if.gnt;
    endfunction

    function automatic logic rv_of(input int id);
        return (id == 0) ? m0_if.rvalid : m1_if.rvalid;
    endfunction

    // Reference: what a granted access must return, applied in grant order
    function automatic exp_t model(input int id);
        exp_t        e;
        logic        we;
        logic [31:0] a, wd, mask;
        logic [3:0]  be;
        bit          mis, bad;
        we  = (id == 0) ? m0_if.we    : m1_if.we;
        a   = (id == 0) ? m0_if.addr  : m1_if.addr;
        wd  = (id == 0) ? m0_if.wdata : m1_if.wdata;
        be  = (id == 0) ? m0_if.be    : m1_if.be;
        mis = (a % 4) != 0;
        bad = 0;
`ifdef DMEM_ARB_ALIGN_CHK_EN
        bad = mis && (!we || be != 4'hF);
`endif
        e.id   = id;
        e.data = 32'h0;
        e.err  = bad;
        e.due  = cyc + 2;
        if (!bad) begin
            if (!we) begin
                e.data = refmem[a[5:2]];
            end else if (be == 4'hF) begin
                refmem[a[5:2]] = wd;
            end else if (be != 4'h0) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                refmem[a[5:2]] = (wd & mask) | (refmem[a[5:2]] & ~mask);
                e.due = cyc + 3;
            end
        end
        return e;
    endfunction

    // Monitor: responses popped and compared; grants feed the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("one_gnt", {31'b0, m0_if.gnt & m1_if.gnt}, 32'h0);
            for (int i = 0; i < 2; i++) begin
                if (rv_of(i)) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rvalid id=%0d cyc=%0d",
                                 i, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", i, e.id);
                        chk("rsp_data",
                            (i == 0) ? m0_if.rdata : m1_if.rdata, e.data);
                        chk("rsp_err",
                            {31'b0, (i == 0) ? m0_if.err : m1_if.err},
                            {31'b0, e.err});
                        chk("rsp_cycle", cyc, e.due);
                    end
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (gnt_of(i)) begin
                    glog.push_back(i);
                    if (sb_en) sb.push_back(model(i));
                end
            end
            if (mem_if.we) wlog.push_back('{cyc, mem_if.a, mem_if.wd});
        end
    end

    task automatic drive(input int id, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
        if (id == 0) begin
            m0_if.req = r; m0_if.we = we; m0_if.addr = a;
            m0_if.wdata = wd; m0_if.be = be;
        end else begin
            m1_if.req = r; m1_if.we = we; m1_if.addr = a;
            m1_if.wdata = wd; m1_if.be = be;
        end
    endtask

    // Hold a request until granted; called just after a rising edge
    task automatic issue(input int id, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         output int tg);
        int n;
        n  = 0;
        tg = -1;
        drive(id, 1'b1, we, a, wd, be);
        while (n < 50) begin
            @(negedge clk);
            if (gnt_of(id)) break;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout id=%0d", id);
        end else begin
            tg = cyc;
        end
        @(posedge clk);
        #1;
        drive(id, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        pre_en  = 1'b1;
        pre_idx = 10'(idx);
        pre_val = v;
        refmem[idx] = v;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic rand_thread(input int id, input int n);
        int          t, g;
        logic [31:0] a;
        for (int k = 0; k < n; k++) begin
            g = $urandom_range(0, 3);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            issue(id, 1'($urandom_range(0, 1)), a, $urandom,
                  4'($urandom_range(0, 15)), t);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog");
        $fatal(1);
    end

    initial begin
        int t, t0a, t0b, t1a, t1b;
        rst    = 1'b1;
        pre_en = 1'b0;
        pre_idx = '0;
        pre_val = '0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) preload(i, 32'h0);
        m0_if.req = 1'b1;
        #1;
        chk("rst_ctl", {25'b0, m0_if.gnt, m1_if.gnt, m0_if.rvalid,
                        m1_if.rvalid, m0_if.err, m1_if.err, mem_if.we},
            32'h0);
        chk("rst_rdata", m0_if.rdata | m1_if.rdata, 32'h0);
        chk("rst_mem", mem_if.a | mem_if.wd, 32'h0);
        m0_if.req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Both requesters held: strict alternation from m0
        fork
            begin
                issue(0, 1'b0, 32'd0, 32'h0, 4'hF, t0a);
                issue(0, 1'b0, 32'd4, 32'h0, 4'hF, t0b);
            end
            begin
                issue(1, 1'b0, 32'd8, 32'h0, 4'hF, t1a);
                issue(1, 1'b0, 32'd12, 32'h0, 4'hF, t1b);
            end
        join
        drain();
        chk("arb_m1_first", t1a, t0a + 2);
        chk("arb_m0_second", t0b, t0a + 4);
        chk("arb_m1_second", t1b, t0a + 6);
        chk("arb_order", glog.size() >= 4 ?
            {glog[0][3:0], glog[1][3:0], glog[2][3:0], glog[3][3:0]} :
            32'hFFFF, 32'h0101);

        // Aligned load
        preload(2, 32'h12345678);
        wlog.delete();
        issue(0, 1'b0, 32'd8, 32'h0, 4'hF, t);
        drain();
        chk("load_no_write", wlog.size(), 0);

        // Full-word store, then read it back
        wlog.delete();
        issue(0, 1'b1, 32'd16, 32'hCAFEBABE, 4'hF, t);
        drain();
        chk("full_wr_count", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("full_wr_cycle", wlog[0].c, t + 1);
            chk("full_wr_addr", wlog[0].a, 32'd16);
            chk("full_wr_data", wlog[0].d, 32'hCAFEBABE);
        end
        issue(0, 1'b0, 32'd16, 32'h0, 4'hF, t);
        drain();

        // Partial store becomes read-modify-write
        wlog.delete();
        issue(1, 1'b1, 32'd8, 32'h000000AB, 4'b0001, t);
        drain();
        chk("rmw_wr_count", wlog.size(), 1);
        if (wlog.size() == 1) begin
            chk("rmw_wr_cycle", wlog[0].c, t + 2);
            chk("rmw_wr_data", wlog[0].d, 32'h123456AB);
        end

        // Misaligned load: error or plain word, depending on build
        wlog.delete();
        issue(0, 1'b0, 32'd10, 32'h0, 4'hF, t);
        drain();
        chk("misalign_no_write", wlog.size(), 0);

        // Reset during ACCESS of a partial store abandons it
        preload(2, 32'h12345678);
        sb_en = 0;
        issue(1, 1'b1, 32'd8, 32'h000000AB, 4'b0001, t);
        rst = 1'b1;
        m0_if.req = 1'b1;
        #1;
        chk("midrst_ctl", {25'b0, m0_if.gnt, m1_if.gnt, m0_if.rvalid,
                           m1_if.rvalid, m0_if.err, m1_if.err, mem_if.we},
            32'h0);
        chk("midrst_mem", mem_if.a | mem_if.wd, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        m0_if.req = 1'b0;
        rst = 1'b0;
        sb_en = 1;
        @(posedge clk);
        #1;
        chk("midrst_word", mem[2], 32'h12345678);
        issue(0, 1'b0, 32'd8, 32'h0, 4'hF, t);
        drain();

        // Random traffic from both sides
        fork
            rand_thread(0, 60);
            rand_thread(1, 60);
        join
        drain();
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], refmem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
